// File: rtl/blob_locator.sv
// Colour-threshold blob tracker: accumulates target-pixel count and row/column sums
// per raster, then divides at end of frame to produce a clamped centroid.
module blob_locator #(
    parameter int         H_ACTIVE  = 800,
    parameter int         V_ACTIVE  = 600,
    parameter logic [7:0] R_TH      = 8'd160,
    parameter logic [7:0] G_TH      = 8'd96,
    parameter logic [7:0] B_TH      = 8'd96,
    parameter int         MIN_COUNT = 64,
    parameter int         HALF      = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    output logic [9:0]  o_row,
    output logic [9:0]  o_col,
    output logic        o_found,
    output logic        o_update
);
    localparam int ITERS = 30;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t      r_state, w_state_nx;
    logic [9:0]  r_row, r_col;
    logic [18:0] r_cnt;
    logic [28:0] r_srow;
    logic [29:0] r_scol;
    logic [18:0] r_dcnt, r_rrow, r_rcol;
    logic [29:0] r_qrow, r_qcol;
    logic [4:0]  r_iter;
    logic [9:0]  r_orow, r_ocol;
    logic        r_found, r_upd;

    logic        w_tgt, w_eol, w_eof, w_start, w_step, w_load, w_unused;
    logic [18:0] w_cnt_nx;
    logic [28:0] w_srow_nx;
    logic [29:0] w_scol_nx;
    logic [48:0] w_drow, w_dcol;

    // One restoring-divide step: returns {remainder, dividend/quotient shift register}.
    function automatic logic [48:0] div_step(input logic [18:0] rem, input logic [29:0] q,
                                             input logic [18:0] d);
        logic [19:0] sh;
        sh = {rem, q[29]};
        if (sh >= {1'b0, d}) div_step = {19'(sh - {1'b0, d}), q[28:0], 1'b1};
        else                 div_step = {sh[18:0], q[28:0], 1'b0};
    endfunction

    function automatic logic [9:0] clamp(input logic [29:0] q, input int lo, input int hi);
        if (q < 30'(lo))      clamp = 10'(lo);
        else if (q > 30'(hi)) clamp = 10'(hi);
        else                  clamp = q[9:0];
    endfunction

    assign w_unused  = ^i_data[31:24];
    assign w_tgt     = i_valid && (i_data[23:16] >= R_TH) && (i_data[15:8] < G_TH)
                       && (i_data[7:0] < B_TH);
    assign w_eol     = (r_col == 10'(H_ACTIVE - 1));
    assign w_eof     = i_valid && w_eol && (r_row == 10'(V_ACTIVE - 1));
    assign w_cnt_nx  = r_cnt + 19'(w_tgt);
    assign w_srow_nx = r_srow + (w_tgt ? 29'(r_row) : 29'd0);
    assign w_scol_nx = r_scol + (w_tgt ? 30'(r_col) : 30'd0);
    assign w_drow    = div_step(r_rrow, r_qrow, r_dcnt);
    assign w_dcol    = div_step(r_rcol, r_qcol, r_dcnt);

    // Raster position and accumulators; the end-of-frame pixel is folded into the
    // divider snapshot while the accumulators restart from zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_row  <= '0;
            r_col  <= '0;
            r_cnt  <= '0;
            r_srow <= '0;
            r_scol <= '0;
        end else if (i_valid) begin
            r_col <= w_eol ? 10'd0 : r_col + 10'd1;
            if (w_eol) r_row <= (r_row == 10'(V_ACTIVE - 1)) ? 10'd0 : r_row + 10'd1;
            if (w_eof) begin
                r_cnt  <= '0;
                r_srow <= '0;
                r_scol <= '0;
            end else begin
                r_cnt  <= w_cnt_nx;
                r_srow <= w_srow_nx;
                r_scol <= w_scol_nx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: if (w_eof) w_state_nx = S_DIV;
            S_DIV:  if (r_iter == 5'(ITERS - 1)) w_state_nx = S_DONE;
            S_DONE: w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_start = (r_state == S_IDLE) && w_eof;
        w_step  = (r_state == S_DIV);
        w_load  = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dcnt <= '0;
            r_rrow <= '0;
            r_rcol <= '0;
            r_qrow <= '0;
            r_qcol <= '0;
            r_iter <= '0;
        end else if (w_start) begin
            r_dcnt <= w_cnt_nx;
            r_qrow <= {1'b0, w_srow_nx};
            r_qcol <= w_scol_nx;
            r_rrow <= '0;
            r_rcol <= '0;
            r_iter <= '0;
        end else if (w_step) begin
            {r_rrow, r_qrow} <= w_drow;
            {r_rcol, r_qcol} <= w_dcol;
            r_iter           <= r_iter + 5'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_orow  <= 10'd300;
            r_ocol  <= 10'd400;
            r_found <= 1'b0;
            r_upd   <= 1'b0;
        end else begin
            r_upd <= w_load;
            if (w_load) begin
                r_found <= (r_dcnt >= 19'(MIN_COUNT));
                if (r_dcnt >= 19'(MIN_COUNT)) begin
                    r_orow <= clamp(r_qrow, HALF, V_ACTIVE - HALF - 1);
                    r_ocol <= clamp(r_qcol, HALF, H_ACTIVE - HALF - 1);
                end
            end
        end
    end

    assign o_row    = r_orow;
    assign o_col    = r_ocol;
    assign o_found  = r_found;
    assign o_update = r_upd;
endmodule

// File: tb/tb_blob_locator.sv
// Scoreboarded bench for blob_locator on a reduced 64x48 raster so whole frames stay short.
module tb_blob_locator;
    localparam int H = 64;
    localparam int V = 48;
    localparam int HF = 8;
    localparam int MINC = 64;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic [9:0]  o_row, o_col;
    logic        o_found, o_update;

    typedef struct {
        logic [9:0] row;
        logic [9:0] col;
        logic       found;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   e0 = 0;
    int   m_row = 300;
    int   m_col = 400;

    blob_locator #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_COUNT(MINC), .HALF(HF)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
        .o_row(o_row), .o_col(o_col), .o_found(o_found), .o_update(o_update)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Every update pulse must match the oldest pending expectation, 31 edges after E0.
    always @(negedge i_clk) begin
        if (i_rst_n && o_update === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_update: o_update=1 at cycle %0d, none expected", cyc);
            end else begin
                e = q.pop_front();
                if (o_row !== e.row || o_col !== e.col || o_found !== e.found) begin
                    bad++;
                    $display("FAIL update_value: got row=%0d col=%0d found=%0d want row=%0d col=%0d found=%0d",
                             o_row, o_col, o_found, e.row, e.col, e.found);
                end
                total++;
                if (cyc - e0 !== 31) begin
                    bad++;
                    $display("FAIL latency: got %0d edges want 31", cyc - e0);
                end
            end
        end
    end

    // Streams one full frame with a solid block; the model result is queued at E0.
    task automatic run_frame(input int r0, input int r1, input int c0, input int c1,
                             input logic [23:0] rgb, input int gap, input bit push);
        bit  tgt;
        int  cnt, sr, sc;
        exp_t x;
        tgt = (rgb[23:16] >= 8'd160) && (rgb[15:8] < 8'd96) && (rgb[7:0] < 8'd96);
        cnt = 0; sr = 0; sc = 0;
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                while (gap > 0 && $urandom_range(0, 99) < gap) begin
                    i_valid = 1'b0;
                    i_data  = $urandom;
                    @(posedge i_clk); #1;
                end
                i_valid = 1'b1;
                if (r >= r0 && r <= r1 && c >= c0 && c <= c1) begin
                    i_data = {8'h00, rgb};
                    if (tgt) begin cnt++; sr += r; sc += c; end
                end else begin
                    i_data = 32'h0;
                end
                @(posedge i_clk); #1;
            end
        end
        e0 = cyc;
        i_valid = 1'b0;
        if (cnt >= MINC) begin
            m_row = sr / cnt;
            m_col = sc / cnt;
            if (m_row < HF) m_row = HF;
            if (m_row > V - HF - 1) m_row = V - HF - 1;
            if (m_col < HF) m_col = HF;
            if (m_col > H - HF - 1) m_col = H - HF - 1;
        end
        x.row = 10'(m_row); x.col = 10'(m_col); x.found = (cnt >= MINC);
        if (push) q.push_back(x);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge i_clk);
        #1;
        total++;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d updates still pending, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        total++;
        if (o_row !== 10'd300 || o_col !== 10'd400 || o_found !== 1'b0 || o_update !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got %0d/%0d/%0d/%0d want 300/400/0/0", o_row, o_col, o_found, o_update);
        end
        i_rst_n = 1'b1;
        run_frame(0, -1, 0, -1, 24'h0, 0, 1);
        drain();
        total++;
        if (o_row !== 10'd300 || o_col !== 10'd400 || o_found !== 1'b0) begin
            bad++;
            $display("FAIL black_frame: got %0d/%0d/%0d want 300/400/0", o_row, o_col, o_found);
        end
    endtask

    task automatic test_centroid();
        run_frame(10, 19, 20, 29, 24'hFF0000, 0, 1);
        drain();
        total++;
        if (o_row !== 10'd14 || o_col !== 10'd24 || o_found !== 1'b1) begin
            bad++;
            $display("FAIL centroid: got %0d/%0d/%0d want 14/24/1", o_row, o_col, o_found);
        end
    endtask

    task automatic test_threshold();
        run_frame(20, 29, 30, 39, 24'hA05F5F, 0, 1);
        drain();
        total++;
        if (o_row !== 10'd24 || o_col !== 10'd34 || o_found !== 1'b1) begin
            bad++;
            $display("FAIL thr_pass: got %0d/%0d/%0d want 24/34/1", o_row, o_col, o_found);
        end
        run_frame(30, 39, 10, 19, 24'h9F5F5F, 0, 1);
        drain();
        total++;
        if (o_row !== 10'd24 || o_col !== 10'd34 || o_found !== 1'b0) begin
            bad++;
            $display("FAIL thr_r159: got %0d/%0d/%0d want 24/34/0", o_row, o_col, o_found);
        end
        run_frame(30, 39, 10, 19, 24'hA0605F, 0, 1);
        drain();
        total++;
        if (o_row !== 10'd24 || o_col !== 10'd34 || o_found !== 1'b0) begin
            bad++;
            $display("FAIL thr_g96: got %0d/%0d/%0d want 24/34/0", o_row, o_col, o_found);
        end
    endtask

    task automatic test_clamp_min();
        run_frame(0, 9, 54, 63, 24'hFF0000, 0, 1);
        drain();
        total++;
        if (o_row !== 10'd8 || o_col !== 10'd55 || o_found !== 1'b1) begin
            bad++;
            $display("FAIL clamp: got %0d/%0d/%0d want 8/55/1", o_row, o_col, o_found);
        end
        run_frame(10, 16, 20, 28, 24'hFF0000, 0, 1);
        drain();
        total++;
        if (o_row !== 10'd8 || o_col !== 10'd55 || o_found !== 1'b0) begin
            bad++;
            $display("FAIL min_count63: got %0d/%0d/%0d want 8/55/0", o_row, o_col, o_found);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(10, 19, 20, 29, 24'hFF0000, 30, 1);
        run_frame(30, 39, 40, 49, 24'hC80A0A, 0, 1);
        drain();
        total++;
        if (o_row !== 10'd34 || o_col !== 10'd44 || o_found !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back: got %0d/%0d/%0d want 34/44/1", o_row, o_col, o_found);
        end
    endtask

    task automatic test_mid_reset();
        run_frame(10, 19, 20, 29, 24'hFF0000, 0, 0);
        repeat (9) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        total++;
        if (o_update !== 1'b0 || o_row !== 10'd300 || o_col !== 10'd400 || o_found !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got upd=%0d %0d/%0d/%0d want 0 300/400/0", o_update, o_row, o_col, o_found);
        end
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        m_row = 300; m_col = 400;
        repeat (40) @(posedge i_clk);
        #1;
        total++;
        if (o_row !== 10'd300 || o_col !== 10'd400 || o_found !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_hold: got %0d/%0d/%0d want 300/400/0", o_row, o_col, o_found);
        end
        run_frame(10, 19, 20, 29, 24'hFF0000, 0, 1);
        drain();
        total++;
        if (o_row !== 10'd14 || o_col !== 10'd24 || o_found !== 1'b1) begin
            bad++;
            $display("FAIL after_reset: got %0d/%0d/%0d want 14/24/1", o_row, o_col, o_found);
        end
    endtask

    initial begin
        test_reset();
        test_centroid();
        test_threshold();
        test_clamp_min();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/blob_locator.md
# blob_locator

Upstream tracking stage for the box-overlay image generator. Scans each incoming 800x600 raster of `{8'b0,R,G,B}` pixels and classifies each pixel as "target" with a fixed colour threshold. It accumulates the target-pixel count and row/column sums, and at end of frame runs an iterative divider to compute the target centroid. The clamped centroid drives the generator's box-centre row/column inputs for the following frame.

## Interface
Parameters:
- `H_ACTIVE`, 800: pixels per line.
- `V_ACTIVE`, 600: lines per frame.
- `R_TH`, 8'd160: pixel is target iff R >= R_TH.
- `G_TH`, 8'd96: target also requires G < G_TH.
- `B_TH`, 8'd96: target also requires B < B_TH.
- `MIN_COUNT`, 64: minimum target pixels for a valid detection.
- `HALF`, 64: box half-size, used for clamping.

Ports:
- `i_clk`, in, 1: single clock; all state on rising edge.
- `i_rst_n`, in, 1: reset; synchronous, active-low.
- `i_valid`, in, 1: `i_data` carries the next raster pixel this cycle.
- `i_data`, in, 32: `{8'b0, R[23:16], G[15:8], B[7:0]}`.
- `o_row`, out, 10: centroid row, clamped.
- `o_col`, out, 10: centroid column, clamped.
- `o_found`, out, 1: last completed frame had count >= MIN_COUNT.
- `o_update`, out, 1: one-cycle pulse when `o_row`/`o_col`/`o_found` are refreshed.

## Operation
- Raster counters `row` (0..599) and `col` (0..799) advance only on cycles with `i_valid`=1.
  - `col` wraps 799→0 and increments `row`.
  - `row` wraps 599→0.
  - Pixel (0,0) is the first pixel accepted after reset.
- Per accepted pixel, if it is a target pixel: `count` += 1 (19 bits), `sum_row` += row (29 bits), `sum_col` += col (30 bits). Widths are sized for the worst case of all 480000 pixels being target; no overflow is possible.
- End of frame is the accepted pixel at (599,799).
  - On that edge, the final sums (including that pixel) are snapshotted into the divider.
  - The accumulators clear at the same edge, so the next frame's first pixel accumulates from zero.
- FSM states: IDLE, DIV, DONE.
  - IDLE→DIV at end of frame.
  - DIV runs 30 iterations of a restoring divide, both quotients in parallel, 1 bit per cycle: `sum_row/count` and `sum_col/count`.
  - DIV→DONE after the 30th iteration.
  - DONE→IDLE after one cycle.
- DONE cycle:
  - If count >= MIN_COUNT: `o_row` = clamp(q_row, HALF, V_ACTIVE-HALF-1) = [64,535]; `o_col` = clamp(q_col, HALF, H_ACTIVE-HALF-1) = [64,735]; `o_found`=1.
  - Otherwise `o_row`/`o_col` hold their previous values and `o_found`=0.
  - `o_update` pulses in both cases.
- Quotients truncate (floor). With count=0, the divider result is don't-care and is always discarded by the MIN_COUNT test.
- An end of frame while the FSM is not IDLE is not possible at 800x600. If it occurs, that frame's result is dropped, but the accumulators still clear.
- Pixel accumulation continues during DIV and DONE, with no stall and no backpressure; the block never drops input pixels.

## Timing
- Reset (`i_rst_n`=0 at an edge) sets:
  - `row`=0, `col`=0, all accumulators 0, FSM IDLE.
  - `o_row`=300, `o_col`=400, `o_found`=0, `o_update`=0.
- Reset mid-DIV or mid-DONE aborts the computation: no `o_update` and no output change other than returning to reset values.
- Latency: let E0 be the edge that accepts pixel (599,799).
  - Division iterations occur on edges E1..E30.
  - Outputs load and `o_update` goes 1 at edge E31.
  - `o_update` returns to 0 at E32.
- Outputs are registered and stable between `o_update` pulses.
- `i_valid` gaps do not affect latency, which is counted from E0.

## Test plan
- Reset: hold `i_rst_n`=0 for 3 cycles → `o_row`=300, `o_col`=400, `o_found`=0, `o_update`=0. Then one all-black frame → `o_update` exactly 31 edges after the last pixel, `o_found`=0, coordinates still 300/400.
- Centroid: red square (R=255, G=B=0) at rows 100..109, cols 200..209 (100 px), background black → `o_row`=104, `o_col`=204, `o_found`=1.
- Threshold edges: 100 px block with RGB=(160,95,95) → `o_found`=1. Same block with R=159, or with G=96 → `o_found`=0 and previous coordinates held.
- Clamp and MIN_COUNT: 100 px block at rows 0..9, cols 790..799 → `o_row`=64, `o_col`=735. A 63-pixel block → `o_found`=0.
- Valid gaps and back-to-back frames: the centroid frame with random `i_valid` deassertion → same 104/204 result. A second, different frame immediately after → correct independent result, with no leakage from the first frame's sums.
- Reset mid-divide: assert reset at E10 → no `o_update` and outputs at reset values. The next full frame produces the correct result.
